sw_arb: RTL

- Per-output-port arbiter of the packet switch; one instance per output port.
- Sits directly downstream of the per-input request generators: bit k of req is input k's request line for this output.
- Grants the output to one input at a time, round-robin among contenders.
- Holds the grant for the whole packet (head to tail). A stalled holder is released after a programmable idle timeout.

---
 rtl/sw_pkg.sv | 11 +
 rtl/sw_arb_rr_pick.sv | 23 ++
 rtl/sw_arb.sv | 81 ++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared switch constants, flit flow codes and arbiter state encoding
package sw_pkg;
    localparam int NPORT = 4;
    localparam int IDXW  = 2;
    localparam int FLOW_LSB = 32;
    localparam int FLOW_MSB = 33;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/sw_arb_rr_pick.sv
// rr_pick: rotating priority encoder, first set request at or after ptr
module rr_pick
    import sw_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             any,
    output logic [IDXW-1:0]  idx
);
    logic [2*NPORT-1:0] dbl;
    logic [IDXW-1:0]    off;
    logic [IDXW:0]      sum;
    assign any = |req;
    // rotate so ptr lands on bit 0, take the lowest set bit, then rotate back
    always_comb begin
        dbl = {req, req} >> ptr;
        off = '0;
        for (int i = NPORT - 1; i >= 0; i--)
            if (dbl[i]) off = IDXW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IDXW+1)'(NPORT)) ? IDXW'(sum - (IDXW+1)'(NPORT)) : sum[IDXW-1:0];
    end
endmodule

// File: rtl/sw_arb.sv
// sw_arb: per-output round-robin packet arbiter with idle-timeout release
module sw_arb
    import sw_pkg::*;
#(
    parameter int TMOW = 4,
    parameter int TMO  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] flit,
    input  logic [NPORT-1:0] tail,
    output logic [NPORT-1:0] grant,
    output logic [IDXW-1:0]  sel,
    output logic             busy,
    output logic             tmo_err
);
    localparam logic [TMOW-1:0] CMAX = TMOW'(TMO - 1);
    state_t           state, state_n;
    logic [IDXW-1:0]  ptr, ptr_n, sel_n, pick;
    logic [TMOW-1:0]  cnt, cnt_n;
    logic [NPORT-1:0] grant_n;
    logic             busy_n, tmo_n, any;
    logic             rel_tail, rel_wd, rel_tmo;

    rr_pick u_pick (.req(req), .ptr(ptr), .any(any), .idx(pick));

    assign rel_tail = flit[sel] & tail[sel];
    assign rel_wd   = ~req[sel];
    assign rel_tmo  = (cnt == CMAX) & ~flit[sel];

    // state, pointer, idle counter and all outputs are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            grant   <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            tmo_err <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            grant   <= grant_n;
            sel     <= sel_n;
            busy    <= busy_n;
            tmo_err <= tmo_n;
        end
    end

    // arbitrate when idle; while owned, release on tail, withdrawal or timeout
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = grant;
        sel_n   = sel;
        busy_n  = busy;
        tmo_n   = 1'b0;
        if (state == IDLE) begin
            if (any) begin
                state_n = BUSY;
                grant_n = NPORT'(1) << pick;
                sel_n   = pick;
                busy_n  = 1'b1;
                cnt_n   = '0;
                ptr_n   = (32'(pick) == NPORT - 1) ? '0 : pick + 1'b1;
            end
        end else if (rel_tail || rel_wd || rel_tmo) begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            tmo_n   = ~rel_tail & ~rel_wd;
        end else begin
            cnt_n = flit[sel] ? '0 : (cnt == CMAX) ? cnt : cnt + 1'b1;
        end
    end
endmodule
